branch_pred_unit: RTL and testbench
===================================

# branch_pred_unit

Parametrised branch unit for the tiny-riscv core. It combines a direct-mapped BTB/BHT (2-bit saturating counters) that predicts at fetch with a resolution stage that evaluates conditional branches and jumps at execute. Branch comparisons are fully signed/unsigned correct. Resolution results, including mispredict detection and redirect PC, are registered one cycle after execute. Two saturating performance counters are maintained.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- ENTRIES, 64, BTB/BHT entries; power of two, ≥2; IDX = log2(ENTRIES)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- fetch_pc  in  XLEN  PC being fetched
- pred_taken  out  1  predicted taken (combinational from table state)
- pred_target  out  XLEN  predicted target; equals fetch_pc+4 when pred_taken=0
- ex_valid  in  1  a control-flow instruction is in execute this cycle
- ex_br_op  in  br_op_t  BEQ/BNE/BLT/BGE/BLTU/BGEU; ignored when ex_jal or ex_jalr
- ex_jal  in  1  JAL
- ex_jalr  in  1  JALR
- ex_pc  in  XLEN  instruction PC
- ex_rs1_data, ex_rs2_data  in  XLEN  operands
- ex_imm  in  XLEN  sign-extended B/J/I immediate
- ex_pred_taken  in  1  prediction that travelled with the instruction
- ex_pred_target  in  XLEN  predicted target that travelled with it
- res_valid  out  1  registered: resolution result valid
- res_taken  out  1  actual direction
- res_mispredict  out  1  fetch must be redirected
- res_redirect_pc  out  XLEN  correct next PC
- res_link  out  XLEN  ex_pc+4 (rd value for JAL/JALR)
- perf_branches  out  CNT_W  resolved control-flow instructions
- perf_mispredicts  out  CNT_W  mispredicts

## Operation
- Table entry i: valid, tag = pc[XLEN-1:IDX+2], target[XLEN], ctr[2]. Index = pc[IDX+1:2].
- Predict: hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = pred_taken ? entry.target : fetch_pc+4.
- Direction: BEQ ==, BNE !=, BLT/BGE signed, BLTU/BGEU unsigned; JAL/JALR always taken; unknown br_op with no jump → not taken.
- Target: branch/JAL = ex_pc+ex_imm; JALR = (rs1+imm) & ~1. All sums modulo 2^XLEN.
- Mispredict = taken != ex_pred_taken, or (taken & ex_pred_taken & target != ex_pred_target).
- redirect_pc = taken ? target : ex_pc+4.
- Table update when ex_valid (index/tag from ex_pc):
  - hit: ctr +1 if taken (sat at 3), −1 if not (sat at 0); target overwritten when taken.
  - miss & taken: allocate/replace: valid=1, tag, target, ctr = 3 for jumps, 2 for branches.
  - miss & not taken: no change.
- Perf: perf_branches +1 per ex_valid; perf_mispredicts +1 per mispredict; both saturate at all-ones.

## Timing
- ex_valid sampled at cycle N → res_* valid during N+1 only; res_valid=0 in any cycle not following an ex_valid. Back-to-back ex_valid gives back-to-back results.
- Table write at the edge ending cycle N; prediction reflects it from N+1. Same-cycle fetch_pc lookup of the entry being written sees the old value.
- Perf counters update at the same edge; visible N+1.
- Reset (any cycle, including mid-resolution): all valid bits cleared, all ctr=1, res_valid/res_taken/res_mispredict=0, res_redirect_pc/res_link=0, perf counters=0. An ex_valid coincident with reset is dropped. After reset pred_taken=0, pred_target=fetch_pc+4.
- No stall input; upstream holds ex_valid low when the instruction is killed.

## Test plan
- Signed compare: BLT rs1=0xFFFFFFFF, rs2=1, pred 0 → N+1 res_taken=1, res_mispredict=1, redirect=ex_pc+imm; BLTU same operands → not taken, no mispredict.
- Training: BEQ at pc 0x100, imm 0x40, taken 3 times; fetch_pc=0x100 then → pred_taken=1, pred_target=0x140; after two not-taken resolutions → pred_taken=0, pred_target=0x104.
- JALR rs1=0x2001, imm=2, pred_taken=1, pred_target=0x2002 → target 0x2002, no mispredict, res_link=ex_pc+4; entry allocated with ctr=3.
- Aliasing (ENTRIES=64): taken branch at 0x100, then taken at 0x200 (same index) → entry replaced; fetch 0x100 → miss, pred_taken=0.
- Same-cycle read/write: fetch_pc=ex_pc during first allocating taken resolve → pred_taken=0 that cycle, 1 next cycle.
- Reset mid-stream plus saturation (CNT_W=4): 20 mispredicts → both counters hold 15; assert reset with ex_valid=1 → next cycle res_valid=0, counters 0, predictions not taken.

Source files
------------

// File: rtl/branch_pred_unit.sv
// Branch unit: direct-mapped BTB/BHT prediction at fetch, branch/jump
// resolution at execute with registered results, saturating perf counters.
module branch_pred_unit #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned CNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   fetch_pc,
   output logic              pred_taken,
   output logic [XLEN-1:0]   pred_target,
   input  logic              ex_valid,
   input  logic [2:0]        ex_br_op,
   input  logic              ex_jal,
   input  logic              ex_jalr,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic [XLEN-1:0]   ex_rs1_data,
   input  logic [XLEN-1:0]   ex_rs2_data,
   input  logic [XLEN-1:0]   ex_imm,
   input  logic              ex_pred_taken,
   input  logic [XLEN-1:0]   ex_pred_target,
   output logic              res_valid,
   output logic              res_taken,
   output logic              res_mispredict,
   output logic [XLEN-1:0]   res_redirect_pc,
   output logic [XLEN-1:0]   res_link,
   output logic [CNT_W-1:0]  perf_branches,
   output logic [CNT_W-1:0]  perf_mispredicts
);

   localparam int unsigned IDX   = $clog2(ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX - 2;

   // Branch op encodings follow the RISC-V funct3 field
   localparam logic [2:0] OP_BEQ  = 3'b000;
   localparam logic [2:0] OP_BNE  = 3'b001;
   localparam logic [2:0] OP_BLT  = 3'b100;
   localparam logic [2:0] OP_BGE  = 3'b101;
   localparam logic [2:0] OP_BLTU = 3'b110;
   localparam logic [2:0] OP_BGEU = 3'b111;

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [XLEN-1:0]   target_q [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];

   logic [IDX-1:0]    f_idx, x_idx;
   logic [TAG_W-1:0]  f_tag, x_tag;
   logic              f_hit, x_hit;

   logic              taken_c;
   logic [XLEN-1:0]   target_c;
   logic [XLEN-1:0]   link_c;
   logic              mispredict_c;

   // PC bits [1:0] never take part in indexing or tagging
   logic unused_pc_bits;
   assign unused_pc_bits = ^{fetch_pc[1:0], ex_pc[1:0]};

   assign f_idx = fetch_pc[IDX+1:2];
   assign f_tag = fetch_pc[XLEN-1:IDX+2];
   assign x_idx = ex_pc[IDX+1:2];
   assign x_tag = ex_pc[XLEN-1:IDX+2];
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign x_hit = valid_q[x_idx] && (tag_q[x_idx] == x_tag);

   // Fetch-side prediction from current table state
   always_comb begin
      pred_taken  = f_hit && ctr_q[f_idx][1];
      pred_target = pred_taken ? target_q[f_idx] : fetch_pc + XLEN'(4);
   end

   // Execute-side direction, target and mispredict evaluation
   always_comb begin
      taken_c = 1'b0;
      if (ex_jal || ex_jalr) begin
         taken_c = 1'b1;
      end else begin
         case (ex_br_op)
            OP_BEQ:  taken_c = (ex_rs1_data == ex_rs2_data);
            OP_BNE:  taken_c = (ex_rs1_data != ex_rs2_data);
            OP_BLT:  taken_c = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
            OP_BGE:  taken_c = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
            OP_BLTU: taken_c = (ex_rs1_data <  ex_rs2_data);
            OP_BGEU: taken_c = (ex_rs1_data >= ex_rs2_data);
            default: taken_c = 1'b0;
         endcase
      end
      target_c = ex_jalr ? ((ex_rs1_data + ex_imm) & ~XLEN'(1)) : (ex_pc + ex_imm);
      link_c   = ex_pc + XLEN'(4);
      mispredict_c = (taken_c != ex_pred_taken) ||
                     (taken_c && ex_pred_taken && (target_c != ex_pred_target));
   end

   // Table training: counter update on hit, allocation on taken miss
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'd1;
         end
      end else if (ex_valid) begin
         if (x_hit) begin
            if (taken_c) begin
               target_q[x_idx] <= target_c;
               if (ctr_q[x_idx] != 2'd3) ctr_q[x_idx] <= ctr_q[x_idx] + 2'd1;
            end else begin
               if (ctr_q[x_idx] != 2'd0) ctr_q[x_idx] <= ctr_q[x_idx] - 2'd1;
            end
         end else if (taken_c) begin
            valid_q[x_idx]  <= 1'b1;
            tag_q[x_idx]    <= x_tag;
            target_q[x_idx] <= target_c;
            ctr_q[x_idx]    <= (ex_jal || ex_jalr) ? 2'd3 : 2'd2;
         end
      end
   end

   // Registered resolution result, valid for one cycle after execute
   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid       <= 1'b0;
         res_taken       <= 1'b0;
         res_mispredict  <= 1'b0;
         res_redirect_pc <= '0;
         res_link        <= '0;
      end else begin
         res_valid       <= ex_valid;
         res_taken       <= ex_valid && taken_c;
         res_mispredict  <= ex_valid && mispredict_c;
         res_redirect_pc <= taken_c ? target_c : link_c;
         res_link        <= link_c;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else if (ex_valid) begin
         if (perf_branches != '1) perf_branches <= perf_branches + CNT_W'(1);
         if (mispredict_c && (perf_mispredicts != '1))
            perf_mispredicts <= perf_mispredicts + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit with hand-computed expectations.
module tb_branch_pred_unit;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [XLEN-1:0]   fetch_pc;
   logic              pred_taken;
   logic [XLEN-1:0]   pred_target;
   logic              ex_valid;
   logic [2:0]        ex_br_op;
   logic              ex_jal, ex_jalr;
   logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic              ex_pred_taken;
   logic [XLEN-1:0]   ex_pred_target;
   logic              res_valid, res_taken, res_mispredict;
   logic [XLEN-1:0]   res_redirect_pc, res_link;
   logic [CNT_W-1:0]  perf_branches, perf_mispredicts;

   int errors = 0;
   int checks = 0;

   branch_pred_unit #(.XLEN(XLEN), .ENTRIES(64), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_br_op(ex_br_op), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
      .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
      .res_redirect_pc(res_redirect_pc), .res_link(res_link),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive inputs just after an edge, step one clock, land 1 time unit past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic jal, input logic jalr, input logic [2:0] op,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
      ex_valid = 1'b1; ex_jal = jal; ex_jalr = jalr; ex_br_op = op;
      ex_pc = pc; ex_rs1_data = rs1; ex_rs2_data = rs2; ex_imm = imm;
      ex_pred_taken = pt; ex_pred_target = ptgt;
   endtask

   task automatic do_ex(input logic jal, input logic jalr, input logic [2:0] op,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
      set_ex(jal, jalr, op, pc, rs1, rs2, imm, pt, ptgt);
      step();
      ex_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ex_valid = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0; ex_br_op = 3'd0;
      ex_pc = '0; ex_rs1_data = '0; ex_rs2_data = '0; ex_imm = '0;
      ex_pred_taken = 1'b0; ex_pred_target = '0; fetch_pc = 32'h100;
      step(); step();
      reset = 1'b0;
      step();

      // Reset state
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_perf_br", 64'(perf_branches), 64'd0);
      check("rst_perf_mp", 64'(perf_mispredicts), 64'd0);
      check("rst_pred_taken", 64'(pred_taken), 64'd0);
      check("rst_pred_target", 64'(pred_target), 64'h104);

      // Signed vs unsigned compare
      do_ex(0, 0, 3'b100, 32'h304, 32'hFFFF_FFFF, 32'h1, 32'h20, 0, 32'h0);
      check("blt_valid", 64'(res_valid), 64'd1);
      check("blt_taken", 64'(res_taken), 64'd1);
      check("blt_mispred", 64'(res_mispredict), 64'd1);
      check("blt_redirect", 64'(res_redirect_pc), 64'h324);
      check("blt_perf_br", 64'(perf_branches), 64'd1);
      check("blt_perf_mp", 64'(perf_mispredicts), 64'd1);
      do_ex(0, 0, 3'b110, 32'h308, 32'hFFFF_FFFF, 32'h1, 32'h20, 0, 32'h0);
      check("bltu_taken", 64'(res_taken), 64'd0);
      check("bltu_mispred", 64'(res_mispredict), 64'd0);
      check("bltu_redirect", 64'(res_redirect_pc), 64'h30C);
      check("bltu_perf_br", 64'(perf_branches), 64'd2);
      check("bltu_perf_mp", 64'(perf_mispredicts), 64'd1);
      do_ex(0, 0, 3'b101, 32'h30C, 32'hFFFF_FFFF, 32'h1, 32'h20, 0, 32'h0);
      check("bge_taken", 64'(res_taken), 64'd0);
      step();
      check("idle_res_valid", 64'(res_valid), 64'd0);

      // Unknown op is not taken
      do_ex(0, 0, 3'b010, 32'h700, 32'h5, 32'h5, 32'h40, 0, 32'h0);
      check("unk_taken", 64'(res_taken), 64'd0);
      check("unk_mispred", 64'(res_mispredict), 64'd0);

      // Training, with same-cycle read of the entry being allocated
      fetch_pc = 32'h100;
      set_ex(0, 0, 3'b000, 32'h100, 32'h5, 32'h5, 32'h40, 0, 32'h0);
      #1;
      check("rw_same_cycle", 64'(pred_taken), 64'd0);
      step();
      ex_valid = 1'b0;
      check("rw_next_cycle", 64'(pred_taken), 64'd1);
      do_ex(0, 0, 3'b000, 32'h100, 32'h5, 32'h5, 32'h40, 0, 32'h0);
      do_ex(0, 0, 3'b000, 32'h100, 32'h5, 32'h5, 32'h40, 0, 32'h0);
      check("train_taken", 64'(pred_taken), 64'd1);
      check("train_target", 64'(pred_target), 64'h140);
      do_ex(0, 0, 3'b000, 32'h100, 32'h5, 32'h6, 32'h40, 1, 32'h140);
      check("nt1_mispred", 64'(res_mispredict), 64'd1);
      check("nt1_redirect", 64'(res_redirect_pc), 64'h104);
      check("nt1_pred", 64'(pred_taken), 64'd1);
      do_ex(0, 0, 3'b000, 32'h100, 32'h5, 32'h6, 32'h40, 1, 32'h140);
      check("nt2_pred", 64'(pred_taken), 64'd0);
      check("nt2_target", 64'(pred_target), 64'h104);

      // JALR target masking, link, allocation with strong counter
      do_ex(0, 1, 3'b000, 32'h408, 32'h2001, 32'h0, 32'h2, 1, 32'h2002);
      check("jalr_taken", 64'(res_taken), 64'd1);
      check("jalr_mispred", 64'(res_mispredict), 64'd0);
      check("jalr_redirect", 64'(res_redirect_pc), 64'h2002);
      check("jalr_link", 64'(res_link), 64'h40C);
      fetch_pc = 32'h408;
      #1;
      check("jalr_pred", 64'(pred_taken), 64'd1);
      check("jalr_pred_tgt", 64'(pred_target), 64'h2002);
      do_ex(0, 0, 3'b001, 32'h408, 32'h7, 32'h7, 32'h10, 1, 32'h2002);
      check("jalr_ctr3", 64'(pred_taken), 64'd1);

      // Aliasing: 0x200 replaces 0x100 in the same slot
      do_ex(0, 0, 3'b000, 32'h100, 32'h1, 32'h1, 32'h40, 0, 32'h0);
      do_ex(0, 0, 3'b000, 32'h200, 32'h1, 32'h1, 32'h10, 0, 32'h0);
      fetch_pc = 32'h100;
      #1;
      check("alias_old_pred", 64'(pred_taken), 64'd0);
      check("alias_old_tgt", 64'(pred_target), 64'h104);
      fetch_pc = 32'h200;
      #1;
      check("alias_new_pred", 64'(pred_taken), 64'd1);
      check("alias_new_tgt", 64'(pred_target), 64'h210);

      // JAL with negative offset, and wrong-target mispredict
      do_ex(1, 0, 3'b000, 32'h500, 32'h0, 32'h0, 32'hFFFF_FFF8, 0, 32'h0);
      check("jal_redirect", 64'(res_redirect_pc), 64'h4F8);
      check("jal_mispred", 64'(res_mispredict), 64'd1);
      do_ex(0, 0, 3'b000, 32'h800, 32'h3, 32'h3, 32'h8, 1, 32'h900);
      check("tgt_mispred", 64'(res_mispredict), 64'd1);
      check("tgt_redirect", 64'(res_redirect_pc), 64'h808);

      // Counter saturation, then reset with a coincident ex_valid
      for (int i = 0; i < 20; i++)
         do_ex(0, 0, 3'b001, 32'h600, 32'h1, 32'h2, 32'h4, 0, 32'h0);
      check("sat_perf_br", 64'(perf_branches), 64'd15);
      check("sat_perf_mp", 64'(perf_mispredicts), 64'd15);
      reset = 1'b1;
      set_ex(0, 0, 3'b001, 32'h600, 32'h1, 32'h2, 32'h4, 0, 32'h0);
      step();
      reset = 1'b0;
      ex_valid = 1'b0;
      check("rst2_res_valid", 64'(res_valid), 64'd0);
      check("rst2_res_mp", 64'(res_mispredict), 64'd0);
      check("rst2_perf_br", 64'(perf_branches), 64'd0);
      check("rst2_perf_mp", 64'(perf_mispredicts), 64'd0);
      check("rst2_pred", 64'(pred_taken), 64'd0);
      check("rst2_pred_tgt", 64'(pred_target), 64'h204);
      step();
      check("rst2_after_valid", 64'(res_valid), 64'd0);
      check("rst2_after_perf", 64'(perf_branches), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
